// File: rtl/tx_scheduler_if.sv
// Requester, ROM and transmitter signals of the tx_scheduler, bundled.
// master = scheduler side, slave = requesters/ROM/transmitter side.
interface tx_scheduler_if #(
  parameter int unsigned AW = 6,
  parameter int unsigned LW = 6
);
  logic [3:0]      req;
  logic [4*AW-1:0] base;
  logic [4*LW-1:0] len;
  logic [3:0]      grant;
  logic [3:0]      done;
  logic            busy;
  logic [AW-1:0]   rom_addr;
  logic [7:0]      rom_data;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            tx_busy;

  modport master (
    input  req, base, len, rom_data, tx_busy,
    output grant, done, busy, rom_addr, tx_data, tx_start
  );

  modport slave (
    output req, base, len, rom_data, tx_busy,
    input  grant, done, busy, rom_addr, tx_data, tx_start
  );
endinterface

// File: rtl/tx_scheduler.sv
// Round-robin scheduler sharing one serial transmitter among four requesters;
// walks a ROM message per grant and paces characters by tx_busy plus GAP.
module tx_scheduler #(
  parameter int unsigned GAP = 0,
  parameter int unsigned AW  = 6,
  parameter int unsigned LW  = 6
) (
  input  logic           sysclk,
  input  logic           rst,
  tx_scheduler_if.master bus
);
  localparam int unsigned NR = 4;
  localparam int unsigned GW = 16;

  typedef enum logic [2:0] {
    IDLE, FETCH, ACK, DRAIN, GAPWAIT, FINISH
  } state_e;

  state_e          state_q, state_d;
  logic [NR-1:0]   grant_q, grant_d;
  logic [NR-1:0]   done_q, done_d;
  logic            busy_q, busy_d;
  logic            tx_start_q, tx_start_d;
  logic            complete_q, complete_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic [AW-1:0]   base_q, base_d, base_pick;
  logic [LW-1:0]   len_q, len_d, len_pick;
  logic [LW-1:0]   idx_q, idx_d, idx_inc;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      pick, cand;
  logic            pick_vld;
  logic [GW-1:0]   gap_q, gap_d;

  assign idx_inc = idx_q + LW'(1);

  // First requesting bit scanning upward from last+1, plus its base/len.
  always_comb begin
    pick_vld  = 1'b0;
    pick      = last_q;
    cand      = last_q;
    base_pick = '0;
    len_pick  = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      cand = last_q + 2'(k);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
    for (int unsigned i = 0; i < NR; i++) begin
      if (pick == 2'(i)) begin
        base_pick = bus.base[i*AW +: AW];
        len_pick  = bus.len[i*LW +: LW];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    rom_addr_d = rom_addr_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    sel_d      = sel_q;
    last_d     = last_q;
    gap_d      = gap_q;
    complete_d = complete_q;

    unique case (state_q)
      IDLE: begin
        // Finished grant stays visible alongside its done pulse for this cycle.
        grant_d = '0;
        if (pick_vld) begin
          grant_d    = 4'b0001 << pick;
          sel_d      = pick;
          base_d     = base_pick;
          len_d      = len_pick;
          idx_d      = '0;
          rom_addr_d = base_pick;
          complete_d = (len_pick == '0);
          state_d    = (len_pick == '0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        tx_data_d  = bus.rom_data;
        tx_start_d = 1'b1;
        state_d    = ACK;
      end
      ACK: begin
        if (bus.tx_busy) state_d = DRAIN;
      end
      DRAIN: begin
        if (!bus.tx_busy) begin
          idx_d = idx_inc;
          if (idx_inc == len_q) begin
            complete_d = 1'b1;
            state_d    = FINISH;
          end else if (!bus.req[sel_q]) begin
            state_d = FINISH;
          end else if (GAP == 0) begin
            rom_addr_d = base_q + AW'(idx_inc);
            state_d    = FETCH;
          end else begin
            gap_d   = GW'(GAP - 1);
            state_d = GAPWAIT;
          end
        end
      end
      GAPWAIT: begin
        if (!bus.req[sel_q]) begin
          state_d = FINISH;
        end else if (gap_q == '0) begin
          rom_addr_d = base_q + AW'(idx_q);
          state_d    = FETCH;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      FINISH: begin
        done_d  = complete_q ? grant_q : '0;
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      rom_addr_q <= '0;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      sel_q      <= '0;
      last_q     <= 2'd3;
      gap_q      <= '0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      rom_addr_q <= rom_addr_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      gap_q      <= gap_d;
      complete_q <= complete_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.rom_addr = rom_addr_q;
endmodule
